// File: rtl/beam_sweep_scheduler.sv
// Beam sweep scheduler for the ultrasonic phased array transmitter.
// Steps the steering angle across [ANGLE_MIN, ANGLE_MAX], samples the external
// sine LUT for each angle, turns |sin| into a per-element delay increment and
// streams one delay per element to the delay bank. Once the bank holds all
// NUM_ELEMENTS delays it fires a burst and waits for completion before moving
// on to the next angle.
//
// Handshake (delay bank): a transfer happens on every rising clk_in edge where
// delay_valid_out and delay_ready_in are both high. While delay_valid_out is
// high and delay_ready_in is low, delay_out, elem_idx_out and angle_out are
// held unchanged. delay_valid_out never drops without a completed transfer.
module beam_sweep_scheduler #(
    parameter int NUM_ELEMENTS = 8,
    parameter int ANGLE_MIN    = -60,
    parameter int ANGLE_MAX    = 60,
    parameter int ANGLE_STEP   = 5,
    parameter int DELAY_SCALE  = 1254,
    parameter int DELAY_WIDTH  = 16,
    parameter bit CONTINUOUS   = 1'b1,
    localparam int IDX_W       = $clog2(NUM_ELEMENTS)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic                   stop_in,
    input  logic [16:0]            sin_value_in,
    input  logic                   sin_sign_in,
    output logic signed [7:0]      angle_out,
    output logic [DELAY_WIDTH-1:0] delay_out,
    output logic [IDX_W-1:0]       elem_idx_out,
    output logic                   delay_valid_out,
    input  logic                   delay_ready_in,
    output logic                   fire_out,
    input  logic                   fire_done_in,
    output logic                   busy_out,
    output logic                   sweep_done_out,
    output logic [2:0]             state_dbg
);

    // Sequencer states; the current state is exported on state_dbg.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SET_ANGLE = 3'd1,
        S_CALC      = 3'd2,
        S_LOAD      = 3'd3,
        S_FIRE      = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_NEXT      = 3'd6
    } state_t;

    // Datapath widths. The product of the 17-bit sine magnitude and the
    // scale constant is kept at full width; dropping the 16 fraction bits
    // leaves the per-element delay increment.
    localparam int SCALE_W = $clog2(DELAY_SCALE + 1);
    localparam int PROD_W  = 17 + SCALE_W;
    localparam int STEP_W  = PROD_W - 16;
    // The accumulator must hold NUM_ELEMENTS * step without wrapping so that
    // saturation sees the true value.
    localparam int ACC_W   = STEP_W + IDX_W + 1;
    localparam int WIDE_W  = ((ACC_W > DELAY_WIDTH) ? ACC_W : DELAY_WIDTH) + 1;

    localparam logic [WIDE_W-1:0]   DELAY_MAX_WIDE = (WIDE_W'(1) << DELAY_WIDTH) - WIDE_W'(1);
    localparam logic [IDX_W-1:0]    LAST_IDX       = IDX_W'(NUM_ELEMENTS - 1);
    localparam logic signed [7:0]   ANGLE_MIN_8    = 8'(ANGLE_MIN);
    localparam logic signed [8:0]   ANGLE_MAX_9    = 9'(ANGLE_MAX);
    localparam logic signed [8:0]   ANGLE_STEP_9   = 9'(ANGLE_STEP);

    state_t             state;
    logic [16:0]        sin_reg;
    logic               sign_reg;
    logic [STEP_W-1:0]  step;
    logic [ACC_W-1:0]   acc;
    logic [IDX_W-1:0]   idx;
    logic               stop_pending;

    logic [PROD_W-1:0]  product;
    logic [STEP_W-1:0]  step_calc;
    logic [ACC_W-1:0]   acc_next;
    logic [IDX_W-1:0]   idx_next;
    logic signed [8:0]  next_angle;
    logic               last_angle;

    // Clamp an accumulated delay to the largest value the delay port can carry.
    function automatic logic [DELAY_WIDTH-1:0] saturate(input logic [ACC_W-1:0] value);
        logic [WIDE_W-1:0] wide;
        wide = WIDE_W'(value);
        if (wide > DELAY_MAX_WIDE) begin
            return {DELAY_WIDTH{1'b1}};
        end
        return DELAY_WIDTH'(wide);
    endfunction

    // Negative angles steer the other way, so elements are loaded from the
    // far end of the array: the last element gets the zero delay.
    function automatic logic [IDX_W-1:0] elem_for(input logic [IDX_W-1:0] count, input logic neg);
        return neg ? (LAST_IDX - count) : count;
    endfunction

    // Delay increment, next accumulator/index and next-angle arithmetic.
    always_comb begin
        product    = PROD_W'(sin_reg) * PROD_W'(DELAY_SCALE);
        step_calc  = STEP_W'(product >> 16);
        acc_next   = acc + ACC_W'(step);
        idx_next   = idx + IDX_W'(1);
        next_angle = $signed({angle_out[7], angle_out}) + ANGLE_STEP_9;
        last_angle = (next_angle > ANGLE_MAX_9);
    end

    assign state_dbg = state;

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= S_IDLE;
            angle_out       <= ANGLE_MIN_8;
            delay_out       <= '0;
            elem_idx_out    <= '0;
            delay_valid_out <= 1'b0;
            fire_out        <= 1'b0;
            busy_out        <= 1'b0;
            sweep_done_out  <= 1'b0;
            stop_pending    <= 1'b0;
            sin_reg         <= '0;
            sign_reg        <= 1'b0;
            step            <= '0;
            acc             <= '0;
            idx             <= '0;
        end else begin
            // Single-cycle pulses default low.
            fire_out       <= 1'b0;
            sweep_done_out <= 1'b0;

            // A stop request is remembered and honoured at the next angle
            // boundary; the current load and burst always run to completion.
            if (stop_in && (state != S_IDLE)) begin
                stop_pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_in && !stop_in) begin
                        angle_out <= ANGLE_MIN_8;
                        busy_out  <= 1'b1;
                        state     <= S_SET_ANGLE;
                    end
                end

                S_SET_ANGLE: begin
                    // angle_out has been stable for this whole cycle.
                    sin_reg  <= sin_value_in;
                    sign_reg <= sin_sign_in;
                    state    <= S_CALC;
                end

                S_CALC: begin
                    step            <= step_calc;
                    acc             <= '0;
                    idx             <= '0;
                    delay_out       <= '0;
                    elem_idx_out    <= elem_for(IDX_W'(0), sign_reg);
                    delay_valid_out <= 1'b1;
                    state           <= S_LOAD;
                end

                S_LOAD: begin
                    if (delay_ready_in) begin
                        if (idx == LAST_IDX) begin
                            delay_valid_out <= 1'b0;
                            fire_out        <= 1'b1;
                            state           <= S_FIRE;
                        end else begin
                            idx          <= idx_next;
                            acc          <= acc_next;
                            delay_out    <= saturate(acc_next);
                            elem_idx_out <= elem_for(idx_next, sign_reg);
                        end
                    end
                end

                S_FIRE: begin
                    state <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    if (fire_done_in) begin
                        // Flag the end of the sweep during the NEXT cycle.
                        sweep_done_out <= last_angle;
                        state          <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (!last_angle && !stop_pending) begin
                        angle_out <= next_angle[7:0];
                        state     <= S_SET_ANGLE;
                    end else if (last_angle && CONTINUOUS && !stop_pending) begin
                        angle_out <= ANGLE_MIN_8;
                        state     <= S_SET_ANGLE;
                    end else begin
                        angle_out    <= ANGLE_MIN_8;
                        stop_pending <= 1'b0;
                        busy_out     <= 1'b0;
                        state        <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// Testbench for beam_sweep_scheduler: sine LUT model, delay bank with
// configurable ready behaviour, burst responder, transfer scoreboard and a
// reference model that lists the expected (angle, element, delay) transfers.
module tb_beam_sweep_scheduler;

    localparam int N           = 8;
    localparam int IDX_W       = $clog2(N);
    localparam int DW          = 16;
    localparam int ANGLE_MIN   = -60;
    localparam int ANGLE_MAX   = 60;
    localparam int ANGLE_STEP  = 5;
    localparam int DELAY_SCALE = 1254;
    localparam int W           = 8 + IDX_W + DW;

    logic                  clk_in;
    logic                  rst_in;
    logic                  start_in;
    logic                  stop_in;
    logic [16:0]           sin_value_in;
    logic                  sin_sign_in;
    logic signed [7:0]     angle_out;
    logic [DW-1:0]         delay_out;
    logic [IDX_W-1:0]      elem_idx_out;
    logic                  delay_valid_out;
    logic                  delay_ready_in;
    logic                  fire_out;
    logic                  fire_done_in;
    logic                  busy_out;
    logic                  sweep_done_out;
    logic [2:0]            state_dbg;

    // Scoreboard and bookkeeping.
    logic [W-1:0] exp_q[$];
    int           exp_fire_q[$];
    int           fired_q[$];
    int           sin_tab[0:180];
    int           total;
    int           bad;
    int           done_cnt;
    int           ready_mode;
    int           fire_lat;
    logic         spurious_req;

    beam_sweep_scheduler #(
        .NUM_ELEMENTS(N),
        .ANGLE_MIN(ANGLE_MIN),
        .ANGLE_MAX(ANGLE_MAX),
        .ANGLE_STEP(ANGLE_STEP),
        .DELAY_SCALE(DELAY_SCALE),
        .DELAY_WIDTH(DW),
        .CONTINUOUS(1'b0)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .start_in(start_in),
        .stop_in(stop_in),
        .sin_value_in(sin_value_in),
        .sin_sign_in(sin_sign_in),
        .angle_out(angle_out),
        .delay_out(delay_out),
        .elem_idx_out(elem_idx_out),
        .delay_valid_out(delay_valid_out),
        .delay_ready_in(delay_ready_in),
        .fire_out(fire_out),
        .fire_done_in(fire_done_in),
        .busy_out(busy_out),
        .sweep_done_out(sweep_done_out),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- combinational sine LUT ----------------
    assign sin_value_in = 17'(sin_tab[int'(angle_out) + 90]);
    assign sin_sign_in  = (int'(angle_out) < 0);

    task automatic init_sin_table();
        real r;
        for (int a = -90; a <= 90; a++) begin
            r = 65536.0 * $sin(((a < 0) ? -a : a) * 3.14159265358979 / 180.0);
            sin_tab[a + 90] = $rtoi(r + 0.5);
        end
    endtask

    task automatic randomize_sin_table();
        for (int a = -90; a <= 90; a++) begin
            sin_tab[a + 90] = (a == 0) ? 0 : int'($urandom_range(0, 65536));
        end
    endtask

    // ---------------- reference model ----------------
    // One burst at angle a: element k from the near end gets k*step, with
    // step = floor(|sin| * DELAY_SCALE / 65536); negative angles count from
    // the highest element index down.
    task automatic add_burst(input int a);
        longint st;
        longint d;
        int     e;
        st = (longint'(sin_tab[a + 90]) * DELAY_SCALE) / 65536;
        for (int k = 0; k < N; k++) begin
            d = k * st;
            if (d > 65535) d = 65535;
            e = (a < 0) ? (N - 1 - k) : k;
            exp_q.push_back({8'(a), IDX_W'(e), DW'(d)});
        end
        exp_fire_q.push_back(a);
    endtask

    task automatic add_angles(input int count);
        for (int k = 0; k < count; k++) begin
            add_burst(ANGLE_MIN + k * ANGLE_STEP);
        end
    endtask

    task automatic clear_books();
        exp_q.delete();
        exp_fire_q.delete();
        fired_q.delete();
        done_cnt = 0;
    endtask

    // ---------------- background drivers / monitor ----------------
    task automatic ready_driver();
        int pat;
        pat = 0;
        forever begin
            @(posedge clk_in);
            #1;
            case (ready_mode)
                0: delay_ready_in = 1'b1;
                1: delay_ready_in = 1'($urandom_range(0, 1));
                2: delay_ready_in = 1'b0;
                default: begin
                    delay_ready_in = (pat == 0 || pat == 3);
                    pat = (pat + 1) % 4;
                end
            endcase
        end
    endtask

    task automatic fire_responder();
        int lat;
        forever begin
            @(negedge clk_in);
            if (fire_out || spurious_req) begin
                lat = (fire_lat > 0) ? fire_lat : int'($urandom_range(1, 12));
                repeat (lat) @(posedge clk_in);
                #1 fire_done_in = 1'b1;
                @(posedge clk_in);
                #1 fire_done_in = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic [W-1:0]     obs;
        logic [W-1:0]     exp;
        int               burst_cnt;
        logic             expect_fire;
        logic             prev_stall;
        logic [W-1:0]     prev_obs;
        burst_cnt   = 0;
        expect_fire = 1'b0;
        prev_stall  = 1'b0;
        prev_obs    = '0;
        forever begin
            @(negedge clk_in);
            obs = {angle_out, elem_idx_out, delay_out};
            if (rst_in) begin
                burst_cnt   = 0;
                expect_fire = 1'b0;
                prev_stall  = 1'b0;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (delay_valid_out !== 1'b1 || obs !== prev_obs) begin
                        bad++;
                        $display("FAIL hold_stable: got valid=%b data=%h want valid=1 data=%h", delay_valid_out, obs, prev_obs);
                    end
                end
                total++;
                if (fire_out !== expect_fire) begin
                    bad++;
                    $display("FAIL fire_timing: got fire=%b want %b at t=%0t", fire_out, expect_fire, $time);
                end
                if (fire_out) fired_q.push_back(int'(angle_out));
                if (sweep_done_out) done_cnt++;
                expect_fire = 1'b0;
                if (delay_valid_out && delay_ready_in) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL xfer_unexpected: got %h want none", obs);
                    end else begin
                        exp = exp_q.pop_front();
                        if (obs !== exp) begin
                            bad++;
                            $display("FAIL xfer: got angle=%0d elem=%0d delay=%0d want angle=%0d elem=%0d delay=%0d",
                                     $signed(obs[W-1 -: 8]), obs[DW +: IDX_W], obs[DW-1:0],
                                     $signed(exp[W-1 -: 8]), exp[DW +: IDX_W], exp[DW-1:0]);
                        end
                    end
                    burst_cnt++;
                    if (burst_cnt == N) begin
                        burst_cnt   = 0;
                        expect_fire = 1'b1;
                    end
                end
                prev_stall = delay_valid_out && !delay_ready_in;
                prev_obs   = obs;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        @(posedge clk_in);
        #1 start_in = 1'b1;
        @(posedge clk_in);
        #1 start_in = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk_in);
        #1 stop_in = 1'b1;
        @(posedge clk_in);
        #1 stop_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk_in);
            #1;
            if (!busy_out) break;
        end
        total++;
        if (busy_out !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_timeout: got busy=%b want 0 within %0d cycles", name, busy_out, budget);
        end
    endtask

    task automatic check_end(input string name, input int want_done);
        logic ok;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: got %0d transfers outstanding want 0", name, exp_q.size());
        end
        ok = (fired_q.size() == exp_fire_q.size());
        for (int i = 0; ok && i < fired_q.size(); i++) begin
            if (fired_q[i] != exp_fire_q[i]) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_bursts: got %0d bursts want %0d (angle list differs)", name, fired_q.size(), exp_fire_q.size());
        end
        total++;
        if (done_cnt != want_done) begin
            bad++;
            $display("FAIL %s_sweep_done: got %0d pulses want %0d", name, done_cnt, want_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        total++; if (angle_out !== 8'(ANGLE_MIN)) begin bad++; $display("FAIL reset_angle: got %0d want %0d", angle_out, ANGLE_MIN); end
        total++; if (delay_out !== '0) begin bad++; $display("FAIL reset_delay: got %0d want 0", delay_out); end
        total++; if (elem_idx_out !== '0) begin bad++; $display("FAIL reset_elem: got %0d want 0", elem_idx_out); end
        total++; if (delay_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", delay_valid_out); end
        total++; if (fire_out !== 1'b0) begin bad++; $display("FAIL reset_fire: got %b want 0", fire_out); end
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        total++; if (sweep_done_out !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", sweep_done_out); end
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_start_stop_same();
        clear_books();
        @(posedge clk_in);
        #1 start_in = 1'b1; stop_in = 1'b1;
        @(posedge clk_in);
        #1 start_in = 1'b0; stop_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL start_stop_busy: got %b want 0", busy_out); end
        // A burst-done pulse while idle must not start anything.
        fire_lat = 1;
        @(posedge clk_in);
        #1 spurious_req = 1'b1;
        @(posedge clk_in);
        #1 spurious_req = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL idle_done_busy: got %b want 0", busy_out); end
        total++; if (delay_valid_out !== 1'b0) begin bad++; $display("FAIL idle_done_valid: got %b want 0", delay_valid_out); end
    endtask

    task automatic test_full_sweep();
        int n_all;
        n_all = (ANGLE_MAX - ANGLE_MIN) / ANGLE_STEP + 1;
        init_sin_table();
        clear_books();
        ready_mode = 0;
        fire_lat   = 10;
        add_angles(n_all);
        pulse_start();
        total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL sweep_busy: got %b want 1", busy_out); end
        total++; if (delay_valid_out !== 1'b0) begin bad++; $display("FAIL latency_c1: got %b want 0", delay_valid_out); end
        @(posedge clk_in);
        #1;
        total++; if (delay_valid_out !== 1'b0) begin bad++; $display("FAIL latency_c2: got %b want 0", delay_valid_out); end
        @(posedge clk_in);
        #1;
        total++; if (delay_valid_out !== 1'b1) begin bad++; $display("FAIL latency_c3: got %b want 1", delay_valid_out); end
        // A start request while busy must be ignored.
        repeat (40) @(posedge clk_in);
        pulse_start();
        wait_idle(6000, "full_sweep");
        check_end("full_sweep", 1);
    endtask

    task automatic test_random_sweep();
        randomize_sin_table();
        clear_books();
        ready_mode = 1;
        fire_lat   = 0;
        add_angles((ANGLE_MAX - ANGLE_MIN) / ANGLE_STEP + 1);
        pulse_start();
        wait_idle(20000, "random_sweep");
        check_end("random_sweep", 1);
    endtask

    task automatic test_stop();
        int c;
        init_sin_table();
        clear_books();
        ready_mode = 3;
        fire_lat   = 10;
        add_angles(3);
        pulse_start();
        for (c = 0; c < 3000; c++) begin
            @(posedge clk_in);
            #1;
            if (delay_valid_out && int'(angle_out) == ANGLE_MIN + 2 * ANGLE_STEP) break;
        end
        total++;
        if (c >= 3000) begin
            bad++;
            $display("FAIL stop_reach_load: got timeout want load at angle %0d", ANGLE_MIN + 2 * ANGLE_STEP);
        end
        pulse_stop();
        wait_idle(3000, "stop");
        repeat (40) @(posedge clk_in);
        check_end("stop", 0);
    endtask

    task automatic test_reset_mid_load();
        int c;
        init_sin_table();
        clear_books();
        ready_mode = 1;
        fire_lat   = 10;
        add_burst(ANGLE_MIN);
        pulse_start();
        for (c = 0; c < 20; c++) begin
            @(posedge clk_in);
            #1;
            if (delay_valid_out) break;
        end
        total++;
        if (delay_valid_out !== 1'b1) begin bad++; $display("FAIL rst_load_reach: got valid=%b want 1", delay_valid_out); end
        repeat (3) @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        total++; if (delay_valid_out !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b want 0", delay_valid_out); end
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", busy_out); end
        total++; if (delay_out !== '0 || elem_idx_out !== '0) begin bad++; $display("FAIL rst_async_data: got delay=%0d elem=%0d want 0 0", delay_out, elem_idx_out); end
        total++; if (angle_out !== 8'(ANGLE_MIN)) begin bad++; $display("FAIL rst_async_angle: got %0d want %0d", angle_out, ANGLE_MIN); end
        clear_books();
        @(negedge clk_in);
        rst_in = 1'b0;
        add_burst(ANGLE_MIN);
        pulse_start();
        pulse_stop();
        wait_idle(2000, "restart");
        check_end("restart", 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        total          = 0;
        bad            = 0;
        done_cnt       = 0;
        rst_in         = 1'b1;
        start_in       = 1'b0;
        stop_in        = 1'b0;
        fire_done_in   = 1'b0;
        delay_ready_in = 1'b1;
        spurious_req   = 1'b0;
        ready_mode     = 0;
        fire_lat       = 10;
        init_sin_table();
        fork
            ready_driver();
            fire_responder();
            monitor();
        join_none
        test_reset();
        test_start_stop_same();
        test_full_sweep();
        test_random_sweep();
        test_stop();
        test_reset_mid_load();
        repeat (5) @(posedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beam_sweep_scheduler.md
Name: beam_sweep_scheduler

Overview:
Sequences the transmit beam sweep for the ultrasonic phased array. Steps the steering angle across a configured range and drives the combinational sine LUT with each angle. Converts the returned sine magnitude/sign into per-element firing delays, streams them to the transmitter delay bank over a valid/ready handshake, then triggers a burst and waits for it to complete before moving to the next angle.

Parameters:
NUM_ELEMENTS, 8, number of transducer elements (>=2)
ANGLE_MIN, -60, first steering angle in degrees (signed, >= -90)
ANGLE_MAX, 60, last allowed steering angle in degrees (<= 90, >= ANGLE_MIN)
ANGLE_STEP, 5, angle increment in degrees (>0)
DELAY_SCALE, 1254, clock cycles of inter-element delay at |sin|=1 (spacing/c*f_clk)
DELAY_WIDTH, 16, width of delay output
CONTINUOUS, 1, 1 = restart at ANGLE_MIN after the last angle; 0 = stop

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
start_in  input  1  one-cycle pulse: begin sweep (ignored unless IDLE)
stop_in  input  1  one-cycle pulse: request stop at next angle boundary
sin_value_in  input  17  LUT magnitude, 65536 = 1.0
sin_sign_in  input  1  LUT sign, 1 = negative angle
angle_out  output  8  signed steering angle to LUT
delay_out  output  DELAY_WIDTH  firing delay in cycles for elem_idx_out
elem_idx_out  output  $clog2(NUM_ELEMENTS)  element receiving delay_out
delay_valid_out  output  1  delay_out/elem_idx_out valid
delay_ready_in  input  1  delay bank accepts
fire_out  output  1  one-cycle pulse: all delays loaded, fire burst
fire_done_in  input  1  pulse: burst finished
busy_out  output  1  high in any state but IDLE
sweep_done_out  output  1  one-cycle pulse after fire_done of the last angle

Behaviour:
- Reset (async, rst_in high): state IDLE, angle_out=ANGLE_MIN, delay_out=0, elem_idx_out=0, delay_valid_out=0, fire_out=0, busy_out=0, sweep_done_out=0, stop_pending=0.
- States: IDLE, SET_ANGLE, CALC, LOAD, FIRE, WAIT_DONE, NEXT.
- IDLE: start_in (without stop_in same cycle) -> SET_ANGLE with angle_out=ANGLE_MIN. start_in and stop_in together in IDLE: stay IDLE. start_in outside IDLE ignored.
- SET_ANGLE (1 cycle): angle_out stable; registers sin_value_in and sin_sign_in at end of cycle -> CALC.
- CALC (1 cycle): step = (sin_reg * DELAY_SCALE) >> 16, full-width product (17 + width of DELAY_SCALE bits), truncated; accumulator=0, counter i=0 -> LOAD.
- LOAD: delay_valid_out=1; delay_out=min(acc, 2^DELAY_WIDTH-1) (saturate); elem_idx_out = i if sign_reg=0, else NUM_ELEMENTS-1-i. On a cycle with valid&&ready: i++, acc+=step; after element i=NUM_ELEMENTS-1 transfers, delay_valid_out drops next cycle -> FIRE. ready low: all outputs hold.
- FIRE: fire_out=1 for exactly one cycle -> WAIT_DONE.
- WAIT_DONE: wait indefinitely for fire_done_in -> NEXT. fire_done_in in any other state is ignored.
- NEXT (1 cycle): compute next = angle + ANGLE_STEP in 9-bit signed (no overflow).
  - If next <= ANGLE_MAX and no stop_pending: angle_out=next -> SET_ANGLE.
  - If next > ANGLE_MAX: sweep_done_out pulses this cycle; CONTINUOUS=1 and no stop_pending -> angle_out=ANGLE_MIN, SET_ANGLE; else -> IDLE.
  - stop_pending with next <= ANGLE_MAX: -> IDLE, no sweep_done.
  - Entering IDLE clears stop_pending and sets angle_out=ANGLE_MIN.
- stop_in in any non-IDLE state sets stop_pending; an in-progress load and burst always complete.
- Last angle is the largest ANGLE_MIN + k*ANGLE_STEP <= ANGLE_MAX.
- Angle 0: LUT returns 0, so all delays are 0; still load, fire and wait.
- Latency: start_in to first delay_valid_out = 3 cycles (SET_ANGLE, CALC, LOAD entry).

Test Plan:
- Angle 30 (sin 32768, sign 0), ready held 1 -> step 627; elem 0..7 get delays 0,627,1254,...,4389; one delay per cycle; fire_out one cycle after last transfer.
- Angle -30 (sign 1) -> elem_idx sequence 7,6,...,0 with delays 0,627,...,4389; element 0 gets 4389.
- ready toggled 1,0,0,1 during LOAD -> no transfer lost or duplicated; delay_out and elem_idx_out stable while ready=0.
- Default parameters, CONTINUOUS=0, fire_done returned 10 cycles after each fire -> 25 bursts at angles -60,-55,...,60; sweep_done_out pulses once; returns to IDLE with busy_out=0.
- stop_in pulsed during LOAD at angle -50 -> that burst completes, then IDLE after its fire_done; no further bursts; no sweep_done.
- rst_in asserted mid-LOAD -> outputs return to reset values immediately (asynchronously); a later start_in restarts at ANGLE_MIN.
